// File: rtl/batalha_pkg.sv
// Shared types and constants for the naval-battle placement and validation path.
// Ship lengths, the hidroaviao shape table and the validator FSM states live here.
package batalha_pkg;

    localparam int BOARD_DIM = 10;

    typedef enum logic [2:0] {
        TIPO_SUBMARINO    = 3'd0,
        TIPO_CRUZADOR     = 3'd1,
        TIPO_HIDROAVIAO   = 3'd2,
        TIPO_ENCOURACADO  = 3'd3,
        TIPO_PORTA_AVIOES = 3'd4
    } tipo_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_WRITE    = 3'd2,
        S_RESP     = 3'd3,
        S_WAIT_LOW = 3'd4
    } estado_e;

    // Entry = {dx[1:0], dy[1:0]}, indexed [rotation][cell]
    localparam logic [3:0] HIDRO_OFF [4][3] = '{
        '{4'b0001, 4'b0100, 4'b1001},
        '{4'b0000, 4'b0101, 4'b1000},
        '{4'b0100, 4'b0001, 4'b0110},
        '{4'b0000, 4'b0101, 4'b0010}
    };

    function automatic logic [2:0] ship_len(input logic [2:0] tipo);
        case (tipo)
            3'd0:    ship_len = 3'd1;
            3'd1:    ship_len = 3'd2;
            3'd2:    ship_len = 3'd3;
            3'd3:    ship_len = 3'd4;
            3'd4:    ship_len = 3'd5;
            default: ship_len = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/shape_offset_gen.sv
// Combinational ship shape expander: returns the (dx,dy) offset of cell k of a ship,
// its length, and whether the type code is invalid. Shared with the CPU placement logic.
module shape_offset_gen (
    input  logic [2:0] tipo,
    input  logic       direcao,
    input  logic [2:0] orientacao,
    input  logic [2:0] k,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic [2:0] len,
    output logic       tipo_invalido
);
    import batalha_pkg::*;

    logic [3:0] hidro_e;
    logic       unused_orient;

    // Only the low two bits select the rotation, so 4 folds onto rotation 0.
    assign unused_orient = orientacao[2];

    always_comb begin
        tipo_invalido = (tipo > 3'd4);
        len           = ship_len(tipo);
        dx            = '0;
        dy            = '0;
        hidro_e       = '0;
        if (tipo == TIPO_HIDROAVIAO) begin
            if (k < 3'd3) hidro_e = HIDRO_OFF[orientacao[1:0]][k[1:0]];
            dx = {1'b0, hidro_e[3:2]};
            dy = {1'b0, hidro_e[1:0]};
        end else if (!tipo_invalido) begin
            if (direcao) dy = k;
            else         dx = k;
        end
    end

endmodule

// File: rtl/validador_embarcacao.sv
// Ship placement validator: checks one cell per cycle against bounds and the occupancy map,
// then writes accepted ships. Define ADJACENCY_CHECK_EN to also forbid ships touching.
module validador_embarcacao #(
    parameter int BOARD_DIM = batalha_pkg::BOARD_DIM,
    parameter int COORD_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valida,
    input  logic [2:0]         tipo,
    input  logic               jogador,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               direcao,
    input  logic [2:0]         orientacao,
    input  logic               clear,
    output logic               conflito,
    output logic               done,
    output logic               busy,
    input  logic               rd_jogador,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_ocupado,
    output logic [6:0]         count_p0,
    output logic [6:0]         count_p1
);
    import batalha_pkg::*;

    localparam int            CELLS   = BOARD_DIM * BOARD_DIM;
    localparam int            CW      = COORD_W + 1;
    localparam int            IW      = $clog2(CELLS);
    localparam logic [CW-1:0] DIM_C   = CW'(BOARD_DIM);
    localparam logic [6:0]    CNT_MAX = 7'(CELLS);

    estado_e                state_q;
    logic                   valida_q;
    logic [2:0]             tipo_q, orient_q, k_q;
    logic                   jog_q, dir_q, flag_q;
    logic [COORD_W-1:0]     x_q, y_q;
    logic [1:0][CELLS-1:0]  board_q;
    logic [1:0][6:0]        cnt_q;
    logic                   conflito_q, done_q, busy_q;

    logic [2:0]    dx, dy, len;
    logic          tipo_inv, last_k;
    logic [CW-1:0] cx, cy;
    logic          cell_oob, cell_occ, cell_conf;
    logic [IW-1:0] wr_idx, rd_idx;

    shape_offset_gen u_shape (
        .tipo          (tipo_q),
        .direcao       (dir_q),
        .orientacao    (orient_q),
        .k             (k_q),
        .dx            (dx),
        .dy            (dy),
        .len           (len),
        .tipo_invalido (tipo_inv)
    );

    function automatic logic occ_at(input logic p, input int cxi, input int cyi);
        if (cxi < 0 || cyi < 0 || cxi >= BOARD_DIM || cyi >= BOARD_DIM) return 1'b0;
        return board_q[p][cyi * BOARD_DIM + cxi];
    endfunction

    // Cell coordinates carry one extra bit so anchor+offset cannot wrap into the board.
    assign cx     = CW'(x_q) + CW'(dx);
    assign cy     = CW'(y_q) + CW'(dy);
    assign last_k = (k_q == len - 3'd1);
    assign wr_idx = IW'(int'(cy) * BOARD_DIM + int'(cx));
    assign rd_idx = IW'(int'(rd_y) * BOARD_DIM + int'(rd_x));

    always_comb begin
        cell_oob = (CW'(x_q) >= DIM_C) || (CW'(y_q) >= DIM_C) || (cx >= DIM_C) || (cy >= DIM_C);
`ifdef ADJACENCY_CHECK_EN
        cell_occ = 1'b0;
        for (int ddy = -1; ddy <= 1; ddy++) begin
            for (int ddx = -1; ddx <= 1; ddx++) begin
                if (occ_at(jog_q, int'(cx) + ddx, int'(cy) + ddy)) cell_occ = 1'b1;
            end
        end
`else
        cell_occ = occ_at(jog_q, int'(cx), int'(cy));
`endif
        cell_conf = cell_oob || cell_occ;
    end

    always_comb begin
        rd_ocupado = 1'b0;
        if (CW'(rd_x) < DIM_C && CW'(rd_y) < DIM_C) rd_ocupado = board_q[rd_jogador][rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            valida_q   <= 1'b0;
            tipo_q     <= '0;
            orient_q   <= '0;
            k_q        <= '0;
            jog_q      <= 1'b0;
            dir_q      <= 1'b0;
            flag_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            board_q    <= '0;
            cnt_q      <= '0;
            conflito_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valida_q <= valida;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        board_q <= '0;
                        cnt_q   <= '0;
                    end else if (valida && !valida_q) begin
                        tipo_q   <= tipo;
                        jog_q    <= jogador;
                        x_q      <= x;
                        y_q      <= y;
                        dir_q    <= direcao;
                        orient_q <= orientacao;
                        k_q      <= '0;
                        flag_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Result registers are loaded on entry to RESP so they are valid with done.
                    if (tipo_inv) begin
                        flag_q     <= 1'b1;
                        conflito_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        flag_q <= flag_q | cell_conf;
                        if (last_k) begin
                            k_q <= '0;
                            if (flag_q | cell_conf) begin
                                conflito_q <= 1'b1;
                                done_q     <= 1'b1;
                                state_q    <= S_RESP;
                            end else begin
                                state_q <= S_WRITE;
                            end
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    board_q[jog_q][wr_idx] <= 1'b1;
                    if (cnt_q[jog_q] < CNT_MAX) cnt_q[jog_q] <= cnt_q[jog_q] + 7'd1;
                    if (last_k) begin
                        conflito_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!valida) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign conflito = conflito_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign count_p0 = cnt_q[0];
    assign count_p1 = cnt_q[1];

endmodule

// File: tb/tb_validador_embarcacao.sv
// Randomized self-checking bench for validador_embarcacao against a cell-list board model.
// Honours ADJACENCY_CHECK_EN the same way as the design.
module tb_validador_embarcacao;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valida = 1'b0;
    logic [2:0] tipo = '0;
    logic       jogador = 1'b0;
    logic [3:0] x = '0, y = '0;
    logic       direcao = 1'b0;
    logic [2:0] orientacao = '0;
    logic       clear = 1'b0;
    logic       conflito, done, busy;
    logic       rd_jogador = 1'b0;
    logic [3:0] rd_x = '0, rd_y = '0;
    logic       rd_ocupado;
    logic [6:0] count_p0, count_p1;

    validador_embarcacao #(.BOARD_DIM(10), .COORD_W(4)) dut (
        .clk(clk), .reset(reset), .valida(valida), .tipo(tipo), .jogador(jogador),
        .x(x), .y(y), .direcao(direcao), .orientacao(orientacao), .clear(clear),
        .conflito(conflito), .done(done), .busy(busy),
        .rd_jogador(rd_jogador), .rd_x(rd_x), .rd_y(rd_y), .rd_ocupado(rd_ocupado),
        .count_p0(count_p0), .count_p1(count_p1)
    );

    always #5 clk = ~clk;

`ifdef ADJACENCY_CHECK_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    int n_chk = 0, n_fail = 0;
    bit mb [2][10][10];
    int mcnt [2];
    bit mconf = 1'b0;
    bit sweep = 1'b0;
    int sdx [5], sdy [5], slen;
    int HX [4][3] = '{'{0, 1, 2}, '{0, 1, 2}, '{1, 0, 1}, '{0, 1, 0}};
    int HY [4][3] = '{'{1, 0, 1}, '{0, 1, 0}, '{0, 1, 2}, '{0, 1, 2}};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        foreach (mb[p, i, j]) mb[p][i][j] = 1'b0;
        mcnt[0] = 0;
        mcnt[1] = 0;
    endfunction

    function automatic void shape(input int t, input int d, input int o);
        slen = (t <= 4) ? t + 1 : 0;
        for (int k = 0; k < 5; k++) begin sdx[k] = 0; sdy[k] = 0; end
        if (t == 2) begin
            for (int k = 0; k < 3; k++) begin sdx[k] = HX[o % 4][k]; sdy[k] = HY[o % 4][k]; end
        end else begin
            for (int k = 0; k < slen; k++) if (d != 0) sdy[k] = k; else sdx[k] = k;
        end
    endfunction

    function automatic bit occ(input int p, input int cx, input int cy);
        if (cx < 0 || cy < 0 || cx >= 10 || cy >= 10) return 1'b0;
        return mb[p][cx][cy];
    endfunction

    function automatic bit predict(input int t, input int p, input int ax, input int ay,
                                   input int d, input int o);
        bit c = 1'b0;
        shape(t, d, o);
        if (t > 4) return 1'b1;
        for (int k = 0; k < slen; k++) begin
            int cx = ax + sdx[k];
            int cy = ay + sdy[k];
            if (ax >= 10 || ay >= 10 || cx >= 10 || cy >= 10) c = 1'b1;
            else if (ADJ) begin
                for (int i = -1; i <= 1; i++)
                    for (int j = -1; j <= 1; j++)
                        if (occ(p, cx + i, cy + j)) c = 1'b1;
            end else if (occ(p, cx, cy)) c = 1'b1;
        end
        return c;
    endfunction

    function automatic bit mrd(input int p, input int rx, input int ry);
        return occ(p, rx, ry);
    endfunction

    // Every cycle the block is idle, its visible state must match the model.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reset && !busy) begin
                chk("count_p0", count_p0, mcnt[0]);
                chk("count_p1", count_p1, mcnt[1]);
                chk("conflito_hold", conflito, mconf);
                chk("done_idle", done, 0);
                chk("rd_ocupado", rd_ocupado, mrd(rd_jogador, rd_x, rd_y));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!sweep) begin
                rd_jogador = 1'($urandom_range(0, 1));
                rd_x = 4'($urandom_range(0, 11));
                rd_y = 4'($urandom_range(0, 11));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic probe(input int p, input int px, input int py, input int exp);
        sweep = 1'b1;
        #2;
        rd_jogador = 1'(p); rd_x = 4'(px); rd_y = 4'(py);
        #1;
        chk("probe_rd", rd_ocupado, exp);
        sweep = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic req(input int t, input int p, input int ax, input int ay, input int d,
                       input int o, input int lit_conf, input int lit_lat);
        bit c;
        int lat, n;
        bit got;
        c   = predict(t, p, ax, ay, d, o);
        lat = (t > 4) ? 2 : (c ? 1 + slen : 1 + 2 * slen);
        if (lit_conf >= 0) chk("model_conf", c, lit_conf);
        if (lit_lat >= 0)  chk("model_lat", lat, lit_lat);
        @(negedge clk);
        tipo = 3'(t); jogador = 1'(p); x = 4'(ax); y = 4'(ay);
        direcao = 1'(d); orientacao = 3'(o);
        valida = 1'b1;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk("busy_start", busy, 1);
                tipo = 3'($urandom); jogador = 1'($urandom); x = 4'($urandom);
                y = 4'($urandom); direcao = 1'($urandom); orientacao = 3'($urandom_range(0, 4));
            end
            got = done;
        end
        if (!got) $display("FAIL done_timeout: no done after %0d cycles", n);
        chk("latency", n, lat);
        chk("conflito", conflito, c);
        if (lit_conf >= 0) chk("conflito_lit", conflito, lit_conf);
        if (!c) begin
            for (int k = 0; k < slen; k++) mb[p][ax + sdx[k]][ay + sdy[k]] = 1'b1;
            mcnt[p] = (mcnt[p] + slen > 100) ? 100 : mcnt[p] + slen;
        end
        mconf = c;
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        @(negedge clk);
        valida = 1'b0;
        n = 0;
        while (n < 5 && busy) begin @(posedge clk); #1; n++; end
        chk("busy_end", busy, 0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_conflito", conflito, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count_p0", count_p0, 0);
        chk("rst_count_p1", count_p1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases with hand-derived results
        req(0, 0, 0, 0, 0, 0, 0, 3);
        probe(0, 0, 0, 1);
        chk("c1_count_p0", count_p0, 1);
        req(0, 1, 0, 0, 0, 0, 0, 3);
        chk("c5_count_p1", count_p1, 1);
        chk("c5_count_p0", count_p0, 1);
        probe(1, 0, 0, 1);
        req(6, 0, 2, 2, 0, 0, 1, 2);
        req(0, 0, 1, 0, 0, 0, ADJ ? 1 : 0, ADJ ? 2 : 3);
        req(4, 0, 6, 2, 0, 0, 1, 6);
        probe(0, 6, 2, 0);
        probe(0, 9, 2, 0);
        do_clear();
        req(1, 0, 3, 3, 1, 0, 0, 5);
        req(3, 0, 0, 4, 0, 0, 1, 5);
        chk("c3_count_p0", count_p0, 2);
        probe(0, 0, 4, 0);
        req(2, 0, 7, 7, 0, 1, 0, 7);
        probe(0, 8, 8, 1);
        probe(0, 9, 7, 1);
        probe(0, 8, 7, 0);
        req(2, 0, 8, 8, 0, 0, 1, 4);
        probe(0, 15, 3, 0);

        // clear coinciding with a valida edge: the edge is dropped
        @(negedge clk);
        clear = 1'b1; valida = 1'b1; tipo = 3'd0; x = 4'd5; y = 4'd5; jogador = 1'b0;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        chk("clr_edge_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("clr_edge_busy2", busy, 0);
        valida = 1'b0;
        @(negedge clk);

        // Randomized requests
        for (int i = 0; i < 80; i++) begin
            int t, r, px, py;
            if ($urandom_range(0, 15) == 0) do_clear();
            r  = $urandom_range(0, 19);
            t  = (r < 18) ? r % 5 : 5 + $urandom_range(0, 2);
            px = $urandom_range(0, 11);
            py = $urandom_range(0, 11);
            if ($urandom_range(0, 15) == 0) px = 15;
            req(t, $urandom_range(0, 1), px, py, $urandom_range(0, 1), $urandom_range(0, 4), -1, -1);
        end

        // Reset during WRITE of a porta-avioes
        do_clear();
        @(negedge clk);
        tipo = 3'd4; jogador = 1'b1; x = 4'd0; y = 4'd9; direcao = 1'b0; orientacao = '0;
        valida = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_write_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        mconf = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count_p0", count_p0, 0);
        chk("arst_count_p1", count_p1, 0);
        chk("arst_conflito", conflito, 0);
        sweep = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < 10; j++) begin
                    rd_jogador = 1'(p); rd_x = 4'(i); rd_y = 4'(j);
                    #1;
                    if (rd_ocupado !== 1'b0) chk("arst_rd", rd_ocupado, 0);
                end
        sweep = 1'b0;
        @(negedge clk);
        valida = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req(4, 1, 0, 9, 0, 0, 0, 11);
        chk("post_rst_count_p1", count_p1, 5);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
